// File: rtl/lstm_cell_state_ram_pkg.sv
// Shared types for the LSTM cell-state RAM (CRAM).
// Provides the datapath word width, the CRAM sequencing state enum and the
// packet structs that carry c_{t-1} to compute and c_t back from compute.
`ifndef LSTM_INPUT_BITS
`define LSTM_INPUT_BITS 16
`endif

package lstm_cell_state_ram_pkg;

    localparam int unsigned CRAM_DATA_BITS = `LSTM_INPUT_BITS;

    typedef enum logic [2:0] {
        CRAM_IDLE,
        CRAM_CLEAR,
        CRAM_RUN,
        CRAM_DRAIN,
        CRAM_DONE
    } cram_state_t;

    // c_{t-1} travelling from CRAM to the compute multiplier
    typedef struct packed {
        logic [CRAM_DATA_BITS-1:0] c_prev;
    } cram_compute_packet_t;

    // c_t travelling from compute back into CRAM
    typedef struct packed {
        logic [CRAM_DATA_BITS-1:0] c_next;
    } compute_cram_packet_t;

endpackage

// File: rtl/lstm_cell_state_ram_delay_chain.sv
// Fixed-latency shift pipe with synchronous flush.
// Ports: clock, reset (sync, active-high, clears every stage),
//        i_data (enters stage 0), o_data (last stage, DEPTH cycles later).
module lstm_cell_state_ram_delay_chain #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Stage shift; reset flushes so no stale entry survives a mid-step reset
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/lstm_cell_state_ram.sv
// LSTM cell-state store (CRAM): supplies c_{t-1} aligned to the gate pipeline
// and captures c_t written back by compute, sequencing one timestep per start.
// Optional feature macro: LSTM_CRAM_PARITY_EN (even parity per stored word,
// sticky o_parity_err on read mismatch).
// Ports:
//   clock, reset        clock; synchronous active-high reset
//   i_start, i_clear    begin timestep (IDLE only); zero units 0..N-1 first
//   i_num_units         N, clamped to DEPTH, sampled with i_start
//   i_issue_valid       gate packet for the next unit enters compute
//   o_issue_ready       RUN and fewer than N units issued
//   o_cram_valid/data   c_{t-1} READ_ALIGN cycles after each handshake
//   i_wb_data           c_t, sampled WB_LATENCY cycles after its handshake
//   o_busy, o_step_done not IDLE; one-cycle pulse when all write-backs land
//   o_parity_err        sticky parity error (0 without the parity feature)
module lstm_cell_state_ram
    import lstm_cell_state_ram_pkg::*;
#(
    parameter int unsigned DATA_BITS  = CRAM_DATA_BITS,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned READ_ALIGN = 5,
    parameter int unsigned WB_LATENCY = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic                         i_clear,
    input  logic [$clog2(DEPTH+1)-1:0]   i_num_units,
    input  logic                         i_issue_valid,
    output logic                         o_issue_ready,
    output logic                         o_cram_valid,
    output logic [DATA_BITS-1:0]         o_cram_data,
    input  logic [DATA_BITS-1:0]         i_wb_data,
    output logic                         o_busy,
    output logic                         o_step_done,
    output logic                         o_parity_err
);

    localparam int unsigned N_W = $clog2(DEPTH + 1);
    localparam int unsigned A_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned P_W = $clog2(WB_LATENCY + 2);
`ifdef LSTM_CRAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_BITS + 1;
`else
    localparam int unsigned MEM_W = DATA_BITS;
`endif

    cram_state_t          r_state, w_state_next;
    logic [N_W-1:0]       r_count, w_count_next;
    logic [N_W-1:0]       r_n, w_n_next, w_n_clamped;
    logic [P_W-1:0]       r_pending;
    logic                 r_issue_ready, w_ready_next;
    logic                 r_busy, w_busy_next;
    logic                 r_step_done, w_done_next;
    logic                 r_cram_valid;
    logic [DATA_BITS-1:0] r_cram_data;

    logic [MEM_W-1:0]     r_mem [DEPTH];

    logic                 w_hs;
    logic                 w_drained;
    logic [MEM_W-1:0]     w_rd_word;
    logic                 w_ra_valid;
    logic [MEM_W-1:0]     w_ra_word;
    logic                 w_wb_valid;
    logic [A_W-1:0]       w_wb_addr;
    logic                 w_clr_we;
    logic                 w_we;
    logic [A_W-1:0]       w_waddr;
    logic [DATA_BITS-1:0] w_wdata;
    logic [MEM_W-1:0]     w_wword;

    compute_cram_packet_t w_wb_pkt;
    cram_compute_packet_t w_cram_pkt;

    assign w_hs        = i_issue_valid & r_issue_ready;
    assign w_n_clamped = (i_num_units > N_W'(DEPTH)) ? N_W'(DEPTH) : i_num_units;
    // The write committing this cycle is the last one when only it remains
    assign w_drained   = (r_pending == '0) || ((r_pending == P_W'(1)) && w_wb_valid);

    // Next-state and next-output decode
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_n_next     = r_n;
        case (r_state)
            CRAM_IDLE: begin
                if (i_start) begin
                    w_n_next     = w_n_clamped;
                    w_count_next = '0;
                    w_state_next = (i_clear && (w_n_clamped != '0)) ? CRAM_CLEAR : CRAM_RUN;
                end
            end
            CRAM_CLEAR: begin
                if (r_count == (r_n - N_W'(1))) begin
                    w_count_next = '0;
                    w_state_next = CRAM_RUN;
                end else begin
                    w_count_next = r_count + N_W'(1);
                end
            end
            CRAM_RUN: begin
                w_count_next = r_count + N_W'(w_hs);
                if (w_count_next >= r_n) begin
                    w_state_next = CRAM_DRAIN;
                end
            end
            CRAM_DRAIN: begin
                if (w_drained) begin
                    w_state_next = CRAM_DONE;
                end
            end
            CRAM_DONE: begin
                w_state_next = CRAM_IDLE;
            end
            default: begin
                w_state_next = CRAM_IDLE;
            end
        endcase
        // Outputs are registered, so they are decoded from the next state
        w_ready_next = (w_state_next == CRAM_RUN) && (w_count_next < w_n_next);
        w_busy_next  = (w_state_next != CRAM_IDLE);
        w_done_next  = (w_state_next == CRAM_DONE);
    end

    // Control and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= CRAM_IDLE;
            r_count       <= '0;
            r_n           <= '0;
            r_pending     <= '0;
            r_issue_ready <= 1'b0;
            r_busy        <= 1'b0;
            r_step_done   <= 1'b0;
            r_cram_valid  <= 1'b0;
            r_cram_data   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_n           <= w_n_next;
            r_pending     <= r_pending + P_W'(w_hs) - P_W'(w_wb_valid);
            r_issue_ready <= w_ready_next;
            r_busy        <= w_busy_next;
            r_step_done   <= w_done_next;
            r_cram_valid  <= w_ra_valid;
            r_cram_data   <= w_ra_word[DATA_BITS-1:0];
        end
    end

    // Read at handshake; idle slots carry zero so cram_data is 0 when not valid.
    // The last align stage is the output register above.
    assign w_rd_word = r_mem[r_count[A_W-1:0]];

    lstm_cell_state_ram_delay_chain #(
        .WIDTH (1 + MEM_W),
        .DEPTH (READ_ALIGN - 1)
    ) u_read_align (
        .clock  (clock),
        .reset  (reset),
        .i_data ({w_hs, (w_hs ? w_rd_word : MEM_W'(0))}),
        .o_data ({w_ra_valid, w_ra_word})
    );

    lstm_cell_state_ram_delay_chain #(
        .WIDTH (1 + A_W),
        .DEPTH (WB_LATENCY)
    ) u_wb_pipe (
        .clock  (clock),
        .reset  (reset),
        .i_data ({w_hs, r_count[A_W-1:0]}),
        .o_data ({w_wb_valid, w_wb_addr})
    );

    // Single write port shared by CLEAR zeroing and write-back commits
    assign w_wb_pkt.c_next = CRAM_DATA_BITS'(i_wb_data);
    assign w_clr_we = (r_state == CRAM_CLEAR);
    assign w_we     = !reset && (w_clr_we || w_wb_valid);
    assign w_waddr  = w_clr_we ? r_count[A_W-1:0] : w_wb_addr;
    assign w_wdata  = w_clr_we ? '0 : DATA_BITS'(w_wb_pkt.c_next);

`ifdef LSTM_CRAM_PARITY_EN
    logic r_parity_err;

    assign w_wword = {^w_wdata, w_wdata};

    // Even parity over the whole stored word must reduce to 0
    always_ff @(posedge clock) begin
        if (reset) begin
            r_parity_err <= 1'b0;
        end else if (w_ra_valid && (^w_ra_word)) begin
            r_parity_err <= 1'b1;
        end
    end

    assign o_parity_err = r_parity_err;
`else
    assign w_wword      = w_wdata;
    assign o_parity_err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wword;
        end
    end

    assign w_cram_pkt.c_prev = CRAM_DATA_BITS'(r_cram_data);
    assign o_cram_data       = DATA_BITS'(w_cram_pkt.c_prev);
    assign o_cram_valid      = r_cram_valid;
    assign o_issue_ready     = r_issue_ready;
    assign o_busy            = r_busy;
    assign o_step_done       = r_step_done;

endmodule

// File: tb/tb_lstm_cell_state_ram.sv
// Self-checking bench for lstm_cell_state_ram (DEPTH=64, READ_ALIGN=5, WB_LATENCY=10).
// Each table row is one clock cycle: inputs driven and registered outputs
// compared just after the rising edge. Row 0 of every segment carries start.
module tb_lstm_cell_state_ram;

    logic        clock;
    logic        reset;
    logic        start;
    logic        clear;
    logic [6:0]  num_units;
    logic        issue_valid;
    logic        issue_ready;
    logic        cram_valid;
    logic [15:0] cram_data;
    logic [15:0] wb_data;
    logic        busy;
    logic        step_done;
    logic        parity_err;

    int checks = 0;
    int errors = 0;

    lstm_cell_state_ram dut (
        .clock         (clock),
        .reset         (reset),
        .i_start       (start),
        .i_clear       (clear),
        .i_num_units   (num_units),
        .i_issue_valid (issue_valid),
        .o_issue_ready (issue_ready),
        .o_cram_valid  (cram_valid),
        .o_cram_data   (cram_data),
        .i_wb_data     (wb_data),
        .o_busy        (busy),
        .o_step_done   (step_done),
        .o_parity_err  (parity_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic        cl;
        logic [6:0]  n;
        logic        iv;
        logic [15:0] wb;
        logic        e_rdy;
        logic        e_cv;
        logic [15:0] e_cd;
        logic        e_busy;
        logic        e_done;
        logic        e_perr;
    } vec_t;

    vec_t v [32];
    int   seg_len;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Default row expectations: busy from row 1 through the done row,
    // ready over [lo,hi], step_done only on the done row
    task automatic new_seg(input int len, input int lo, input int hi, input int dn,
                           input logic [6:0] n, input logic cl);
        seg_len = len;
        for (int i = 0; i < len; i++) begin
            v[i].st     = (i == 0);
            v[i].cl     = (i == 0) ? cl : 1'b0;
            v[i].n      = (i == 0) ? n : 7'd0;
            v[i].iv     = 1'b0;
            v[i].wb     = 16'h0000;
            v[i].e_rdy  = (i >= lo) && (i <= hi);
            v[i].e_cv   = 1'b0;
            v[i].e_cd   = 16'h0000;
            v[i].e_busy = (i >= 1) && (i <= dn);
            v[i].e_done = (i == dn);
            v[i].e_perr = 1'b0;
        end
    endtask

    task automatic iv_at(input int r);
        v[r].iv = 1'b1;
    endtask

    task automatic cv_at(input int r, input logic [15:0] d);
        v[r].e_cv = 1'b1;
        v[r].e_cd = d;
    endtask

    task automatic wb_at(input int r, input logic [15:0] d);
        v[r].wb = d;
    endtask

    task automatic run_seg(input string name);
        for (int r = 0; r < seg_len; r++) begin
            start       = v[r].st;
            clear       = v[r].cl;
            num_units   = v[r].n;
            issue_valid = v[r].iv;
            wb_data     = v[r].wb;
            chk($sformatf("%s r%0d ready", name, r), 16'(issue_ready), 16'(v[r].e_rdy));
            chk($sformatf("%s r%0d cram_valid", name, r), 16'(cram_valid), 16'(v[r].e_cv));
            chk($sformatf("%s r%0d cram_data", name, r), cram_data, v[r].e_cd);
            chk($sformatf("%s r%0d busy", name, r), 16'(busy), 16'(v[r].e_busy));
            chk($sformatf("%s r%0d step_done", name, r), 16'(step_done), 16'(v[r].e_done));
            chk($sformatf("%s r%0d parity_err", name, r), 16'(parity_err), 16'(v[r].e_perr));
            tick();
        end
        start = 1'b0; clear = 1'b0; num_units = 7'd0; issue_valid = 1'b0; wb_data = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          hs;
        int          ncv;
        int          bad;
        logic        done_seen;
        logic [15:0] got [4];

        reset = 1'b1; start = 1'b0; clear = 1'b0; num_units = 7'd0;
        issue_valid = 1'b0; wb_data = 16'h0000;
        repeat (3) tick();
        chk("reset ready", 16'(issue_ready), 16'h0);
        chk("reset cram_valid", 16'(cram_valid), 16'h0);
        chk("reset cram_data", cram_data, 16'h0);
        chk("reset busy", 16'(busy), 16'h0);
        chk("reset step_done", 16'(step_done), 16'h0);
        chk("reset parity_err", 16'(parity_err), 16'h0);
        reset = 1'b0;

        // Clear N=4, then four back-to-back issues reading zeros
        new_seg(21, 5, 8, 19, 7'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            iv_at(5 + i);
            cv_at(10 + i, 16'h0000);
            wb_at(15 + i, 16'((i + 1) * 256));
        end
        run_seg("clear_step");

        // No clear: previous write-backs come back in unit order
        new_seg(17, 1, 4, 15, 7'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            iv_at(1 + i);
            cv_at(6 + i, 16'((i + 1) * 256));
            wb_at(11 + i, 16'((i + 1) * 16'h0111));
        end
        run_seg("read_back");

        // Two-cycle issue gap between units 1 and 2
        new_seg(19, 1, 6, 17, 7'd4, 1'b0);
        iv_at(1); iv_at(2); iv_at(5); iv_at(6);
        cv_at(6, 16'h0111); cv_at(7, 16'h0222); cv_at(10, 16'h0333); cv_at(11, 16'h0444);
        wb_at(11, 16'h8001); wb_at(12, 16'h7FFF);
        wb_at(13, 16'hDEAD); wb_at(14, 16'hDEAD);
        wb_at(15, 16'hFFFF); wb_at(16, 16'h0A0A);
        run_seg("gap");

        // N=0 with clear: straight through, clear skipped
        new_seg(5, 1, 0, 3, 7'd0, 1'b1);
        run_seg("n_zero");

        // N=100 clamps to 64 handshakes; first reads prove the gap-step writes
        start = 1'b1; num_units = 7'd100; wb_data = 16'h0005;
        tick();
        start = 1'b0; num_units = 7'd0; issue_valid = 1'b1;
        hs = 0; ncv = 0; done_seen = 1'b0;
        for (int i = 0; i < 4; i++) got[i] = 16'h0000;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (issue_ready) hs++;
            if (cram_valid) begin
                if (ncv < 4) got[ncv] = cram_data;
                ncv++;
            end
            if (step_done) done_seen = 1'b1;
            tick();
        end
        issue_valid = 1'b0; wb_data = 16'h0000;
        chk("clamp handshakes", 16'(hs), 16'd64);
        chk("clamp cram_valid count", 16'(ncv), 16'd64);
        chk("clamp step_done seen", 16'(done_seen), 16'h1);
        chk("clamp unit0", got[0], 16'h8001);
        chk("clamp unit1", got[1], 16'h7FFF);
        chk("clamp unit2", got[2], 16'hFFFF);
        chk("clamp unit3", got[3], 16'h0A0A);
        chk("clamp idle after", 16'(busy), 16'h0);

        // start asserted during RUN must be ignored
        new_seg(16, 1, 3, 14, 7'd3, 1'b0);
        iv_at(1); iv_at(2); iv_at(3);
        v[2].st = 1'b1; v[2].cl = 1'b1; v[2].n = 7'd0;
        for (int i = 0; i < 3; i++) begin
            cv_at(6 + i, 16'h0005);
            wb_at(11 + i, 16'(16'h0C01 + i));
        end
        run_seg("start_in_run");

        // Reset three cycles into RUN drops pending write-backs
        start = 1'b1; num_units = 7'd4;
        tick();
        start = 1'b0; num_units = 7'd0; issue_valid = 1'b1;
        repeat (3) tick();
        issue_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset ready", 16'(issue_ready), 16'h0);
        chk("midreset cram_valid", 16'(cram_valid), 16'h0);
        chk("midreset cram_data", cram_data, 16'h0);
        chk("midreset busy", 16'(busy), 16'h0);
        chk("midreset step_done", 16'(step_done), 16'h0);
        wb_data = 16'hBAD0;
        bad = 0;
        repeat (15) begin
            if (cram_valid || busy || step_done || issue_ready) bad++;
            tick();
        end
        wb_data = 16'h0000;
        chk("midreset quiet cycles", 16'(bad), 16'h0);

        // Contents must be untouched by the dropped write-backs
        new_seg(17, 1, 4, 15, 7'd4, 1'b0);
        for (int i = 0; i < 4; i++) iv_at(1 + i);
        cv_at(6, 16'h0C01); cv_at(7, 16'h0C02); cv_at(8, 16'h0C03); cv_at(9, 16'h0005);
        run_seg("after_reset");

`ifdef LSTM_CRAM_PARITY_EN
        // Corrupt one stored bit of unit 1 (now 0); data still delivered, error sticks
        dut.r_mem[1] = dut.r_mem[1] ^ 17'h00008;
        new_seg(17, 1, 4, 15, 7'd4, 1'b0);
        for (int i = 0; i < 4; i++) iv_at(1 + i);
        cv_at(6, 16'h0000); cv_at(7, 16'h0008); cv_at(8, 16'h0000); cv_at(9, 16'h0000);
        for (int r = 7; r < 17; r++) v[r].e_perr = 1'b1;
        run_seg("parity");
        repeat (3) tick();
        chk("parity sticky", 16'(parity_err), 16'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
